// File: rtl/sr_latch_nor.sv
// sr_latch_nor: bank of independent clocked SR cells with NOR-latch output semantics and a forbidden-code flag
module sr_latch_nor #(
  parameter int unsigned WIDTH = 1,
  parameter bit RESET_Q = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] invalid
);
  logic [WIDTH-1:0] q_n, qb_n, inv_n, hold;
  always_comb begin
    hold  = ~s & ~r;
    inv_n = s & r;
    q_n   = (s & ~r) | (hold & q);
    // holding out of the both-low state snaps qb high, so the cell settles cleared
    qb_n  = (~s & r) | (hold & (qb | ~q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q       <= {WIDTH{RESET_Q}};
      qb      <= {WIDTH{~RESET_Q}};
      invalid <= '0;
    end else begin
      q       <= q_n;
      qb      <= qb_n;
      invalid <= inv_n;
    end
endmodule

// File: tb/tb_sr_latch_nor.sv
// tb_sr_latch_nor: directed and random scoreboard checks of a 4-cell sr_latch_nor
module tb_sr_latch_nor;
  localparam int W = 4;
  typedef struct {
    string      tag;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic [W-1:0] inv;
  } exp_t;
  logic clk = 0, rst = 0;
  logic [W-1:0] s = '0, r = '0, q, qb, invalid;
  logic [W-1:0] mq = '0, mqb = '1, minv = '0;
  exp_t sb[$];
  int total = 0, bad = 0;

  sr_latch_nor #(.WIDTH(W), .RESET_Q(1'b0)) dut (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qb(qb), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (rst) begin
      mq = '0; mqb = '1; minv = '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (s[i] && r[i]) begin mq[i] = 0; mqb[i] = 0; minv[i] = 1; end
        else if (s[i]) begin mq[i] = 1; mqb[i] = 0; minv[i] = 0; end
        else if (r[i]) begin mq[i] = 0; mqb[i] = 1; minv[i] = 0; end
        else begin
          if (!mq[i] && !mqb[i]) begin mq[i] = 0; mqb[i] = 1; end
          minv[i] = 0;
        end
      end
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag; e.q = mq; e.qb = mqb; e.inv = minv;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty q=%b qb=%b inv=%b expected a queued entry", q, qb, invalid);
    end else begin
      e = sb.pop_front();
      assert (q === e.q && qb === e.qb && invalid === e.inv) else begin
        bad++;
        $error("FAIL %s q=%b qb=%b inv=%b expected q=%b qb=%b inv=%b",
               e.tag, q, qb, invalid, e.q, e.qb, e.inv);
      end
    end
  endtask

  task automatic step(input logic [W-1:0] sv, input logic [W-1:0] rv, input string tag);
    @(negedge clk);
    s = sv; r = rv;
    model_update();
    push(tag);
    @(posedge clk);
    #1 check();
  endtask

  task automatic assert_rst_mid(input string tag);
    @(negedge clk);
    #2 rst = 1;
    model_update();
    push(tag);
    #1 check();
  endtask

  initial begin
    #1 rst = 1;
    model_update();
    push("reset_async_init");
    #1 check();
    step('0, '0, "reset_held_clk");
    step('1, '0, "reset_ignores_set");
    step('0, '0, "reset_held2");
    @(negedge clk) rst = 0;
    for (int i = 0; i < 10; i++) step('0, '0, "idle_after_reset");
    step('1, '0, "set");
    for (int i = 0; i < 10; i++) step('0, '0, "set_hold");
    step('1, '0, "set_repeat");
    step('0, '1, "clear");
    for (int i = 0; i < 3; i++) step('0, '0, "clear_hold");
    step('0, '1, "clear_repeat");
    step('1, '1, "forbidden");
    step('0, '0, "forbidden_resolve");
    step('1, '0, "set_before_rst");
    assert_rst_mid("rst_mid_cycle_set");
    step('1, '0, "rst_held_set1");
    step('1, '0, "rst_held_set2");
    @(negedge clk) rst = 0; s = '0;
    step('1, '1, "forbidden_before_rst");
    assert_rst_mid("rst_mid_cycle_forbidden");
    step('1, '1, "rst_held_forbidden");
    @(negedge clk) rst = 0; s = '0; r = '0;
    step(4'b0001, 4'b0000, "indep_set_b0");
    step(4'b0000, 4'b0010, "indep_clear_b1");
    step(4'b1000, 4'b0000, "indep_set_b3");
    step(4'b0000, 4'b1001, "indep_clear_b0_b3");
    step(4'b0101, 4'b0011, "mixed_codes");
    step(4'b0000, 4'b0000, "mixed_resolve");
    for (int i = 0; i < 24; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
    step('0, '0, "random_tail");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout q=%b qb=%b inv=%b expected completion", q, qb, invalid);
    $fatal(1, "timeout");
  end
endmodule
